// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared constants for the program loader
// Purpose: FSM state encoding, frame byte-order constants and the
//          instruction memory capacity derived from the address width.
// Ports:   none (package)
package program_loader_pkg;

  // FSM states, 4-bit encoding
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CHECK   = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  // Frame fields are big-endian: the first byte of a pair lands in bits 15:8
  localparam int HI_BYTE_LSB = 8;
  localparam int LO_BYTE_LSB = 0;

  localparam int ADDR_W_DEFAULT = 8;

  function automatic int max_words(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int MAX_WORDS = max_words(ADDR_W_DEFAULT);

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader for instruction memory
// Purpose: assembles big-endian 16-bit words from a host byte stream, writes
//          them to instruction memory from address 0, holds the core in reset
//          while loading and releases it only after a matching checksum.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start              single-cycle load request (ignored while busy)
//   i_in_data/i_in_valid host byte stream; o_in_ready accepts a byte
//   o_imem_wen/addr/wdata instruction memory write port
//   o_core_reset         high while the core must be held
//   o_busy/o_done/o_error load status
//   o_words_loaded       words written in the current or last load
// ADDR_W is supported up to 16 (the length field is 16 bits wide).
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_imem_wen,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [15:0]       o_imem_wdata,
  output logic              o_core_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam int CAP_WORDS = max_words(ADDR_W);

  logic [3:0]        r_state;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [7:0]        r_hi;
  logic [7:0]        r_acc;
  logic [ADDR_W:0]   r_index;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_core_reset;

  logic              w_accept;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic [15:0]       w_word;
  logic [ADDR_W:0]   w_index_next;
  logic              w_last;

  assign w_accept     = i_in_valid & o_in_ready;
  assign w_len        = (16'(r_len_hi) << HI_BYTE_LSB) | (16'(i_in_data) << LO_BYTE_LSB);
  assign w_len_bad    = (w_len == 16'd0) || (17'(w_len) > 17'(CAP_WORDS));
  assign w_word       = (16'(r_hi) << HI_BYTE_LSB) | (16'(i_in_data) << LO_BYTE_LSB);
  assign w_index_next = r_index + (ADDR_W+1)'(1);
  assign w_last       = (17'(w_index_next) == 17'(r_len));

  always_comb begin
    o_in_ready = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: o_in_ready = 1'b1;
      default: o_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_hi         <= '0;
      r_acc        <= '0;
      r_index      <= '0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state      <= S_LEN_HI;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_reset <= 1'b1;
            r_index      <= '0;
            r_acc        <= '0;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= i_in_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len_bad) begin
              r_state <= S_ERR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else begin
              r_state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            r_hi    <= i_in_data;
            r_acc   <= r_acc + i_in_data;
            r_state <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          // Write port is registered here so the pulse is visible for
          // exactly the one WRITE cycle.
          if (w_accept) begin
            r_acc   <= r_acc + i_in_data;
            r_wen   <= 1'b1;
            r_addr  <= r_index[ADDR_W-1:0];
            r_wdata <= w_word;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_index <= w_index_next;
          r_state <= w_last ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          if (w_accept) begin
            r_busy <= 1'b0;
            if (i_in_data == r_acc) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset masks a pending write so the memory never samples one on the
  // reset edge.
  assign o_imem_wen     = r_wen & ~i_reset;
  assign o_imem_addr    = r_addr;
  assign o_imem_wdata   = r_wdata;
  assign o_core_reset   = r_core_reset;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_index;

endmodule
